// File: rtl/share_refresh_pipe.sv
// Remasks NSHARES Boolean shares with fresh randomness and carries them through STAGES registers.
// Data and randomness are accepted together. Output backpressure stalls the pipeline, and bubbles collapse upstream.
module share_refresh_pipe #(
  parameter int NSHARES = 4,
  parameter int WIDTH   = 8,
  parameter int STAGES  = 2,
  parameter int MODE    = 0,
  parameter int RAND_W  = NSHARES * WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NSHARES*WIDTH-1:0]   in_shares,
  input  logic                       rnd_valid,
  output logic                       rnd_ready,
  input  logic [RAND_W-1:0]          rnd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NSHARES*WIDTH-1:0]   out_shares,
  output logic [15:0]                xfer_cnt
);

  localparam int DW = NSHARES * WIDTH;
  localparam int H  = WIDTH / 2 - 1;

  logic [DW-1:0]     masked;
  logic [WIDTH-1:0]  r_cur;
  logic [WIDTH-1:0]  r_prev;
  logic [STAGES-1:0] vld;
  logic [DW-1:0]     dat [STAGES];
  logic [STAGES-1:0] can;
  logic [STAGES-1:0] src_vld;
  logic [DW-1:0]     src_dat [STAGES];
  logic              fire;

  // MODE 0 flips mirrored bit pairs (j, WIDTH-1-j) together, so each pair's XOR survives.
  always_comb begin
    masked = in_shares;
    r_cur  = '0;
    r_prev = '0;
    for (int i = 0; i < NSHARES; i++) begin
      r_cur  = rnd[i*WIDTH +: WIDTH];
      r_prev = rnd[((i + NSHARES - 1) % NSHARES)*WIDTH +: WIDTH];
      if (MODE == 0) begin
        for (int j = 0; j < H; j++) begin
          masked[i*WIDTH + WIDTH - 1 - H + j] = masked[i*WIDTH + WIDTH - 1 - H + j] ^ r_cur[j];
          masked[i*WIDTH + 1 + j]             = masked[i*WIDTH + 1 + j] ^ r_cur[H-1-j];
        end
      end else begin
        masked[i*WIDTH +: WIDTH] = masked[i*WIDTH +: WIDTH] ^ r_cur ^ r_prev;
      end
    end
  end

  // A stage can take new data if it or any stage below it holds a bubble, or the output drains.
  always_comb begin
    can = '0;
    for (int k = 0; k < STAGES; k++) begin
      can[k] = out_ready;
      for (int m = k; m < STAGES; m++) begin
        if (!vld[m]) can[k] = 1'b1;
      end
    end
  end

  assign in_ready  = can[0] & ~flush & ~rst;
  assign fire      = in_valid & rnd_valid & in_ready;
  assign rnd_ready = fire;

  for (genvar k = 0; k < STAGES; k++) begin : g_src
    if (k == 0) begin : g_head
      assign src_vld[k] = fire;
      assign src_dat[k] = masked;
    end else begin : g_body
      assign src_vld[k] = vld[k-1];
      assign src_dat[k] = dat[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld      <= '0;
      xfer_cnt <= '0;
      for (int k = 0; k < STAGES; k++) dat[k] <= '0;
    end else begin
      if (fire) xfer_cnt <= xfer_cnt + 16'd1;
      for (int k = 0; k < STAGES; k++) begin
        if (flush)       vld[k] <= 1'b0;
        else if (can[k]) vld[k] <= src_vld[k];
        if (can[k] && src_vld[k]) dat[k] <= src_dat[k];
      end
    end
  end

  assign out_valid  = vld[STAGES-1];
  assign out_shares = dat[STAGES-1];

endmodule

// File: tb/tb_share_refresh_pipe.sv
// Bench for share_refresh_pipe: one MODE 0 and one MODE 1 instance share the same stimulus.
module tb_share_refresh_pipe;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, rnd_valid, out_ready;
  logic [DW-1:0] in_shares, rnd;
  logic          in_ready0, rnd_ready0, out_valid0;
  logic [DW-1:0] out_shares0;
  logic [15:0]   xfer_cnt0;
  logic          in_ready1, rnd_ready1, out_valid1;
  logic [DW-1:0] out_shares1;
  logic [15:0]   xfer_cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  share_refresh_pipe #(.NSHARES(4), .WIDTH(8), .STAGES(2), .MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_shares(in_shares),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready0), .rnd(rnd),
    .out_valid(out_valid0), .out_ready(out_ready), .out_shares(out_shares0),
    .xfer_cnt(xfer_cnt0)
  );

  share_refresh_pipe #(.NSHARES(4), .WIDTH(8), .STAGES(2), .MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_shares(in_shares),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready1), .rnd(rnd),
    .out_valid(out_valid1), .out_ready(out_ready), .out_shares(out_shares1),
    .xfer_cnt(xfer_cnt1)
  );

  typedef struct {
    string         name;
    logic [DW-1:0] din;
    logic [DW-1:0] r;
    logic [DW-1:0] exp0;
    logic [DW-1:0] exp1;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] item(input int n);
    logic [7:0] b;
    b = 8'(n * 17 + 3);
    return {b, b, b, b};
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int            pulses, sent, rcv;
    logic          saw_full, hold_vld, f, o;
    logic [DW-1:0] hold_val;
    logic [15:0]   cnt_b;

    vecs[0] = '{"m0_spec_5a_66", 32'h0000_0000, 32'hFF00_0605, 32'h7E00_665A, 32'hFF06_03FA};
    vecs[1] = '{"onehot_rnd",    32'h0000_0000, 32'h0804_0201, 32'h0042_2418, 32'h0C06_0309};
    vecs[2] = '{"zero_rnd_pass", 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3] = '{"upper_rnd_ign", 32'h8181_8181, 32'hF8F8_F8F8, 32'h8181_8181, 32'h8181_8181};
    vecs[4] = '{"share0_only",   32'h1234_5678, 32'h0000_0007, 32'h1234_5606, 32'h1234_517F};
    vecs[5] = '{"all_ones",      32'hFFFF_FFFF, 32'h0303_0303, 32'hC3C3_C3C3, 32'hFFFF_FFFF};
    vecs[6] = '{"share1_only",   32'h0000_0000, 32'h0000_0100, 32'h0000_1800, 32'h0001_0100};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b1;
    in_shares = '0; rnd = '0;
    #12;
    chk("reset_out_valid", 32'(out_valid0), 32'd0);
    chk("reset_out_shares", out_shares0, 32'd0);
    chk("reset_xfer_cnt", 32'(xfer_cnt0), 32'd0);
    chk("reset_rnd_ready", 32'(rnd_ready0), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Each vector: fire, then the result must appear exactly two edges later.
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      in_shares = vecs[v].din; rnd = vecs[v].r; in_valid = 1'b1; rnd_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; rnd_valid = 1'b0;
      #1 chk({vecs[v].name, "_lat1_valid"}, 32'(out_valid0), 32'd0);
      @(negedge clk);
      #1;
      chk({vecs[v].name, "_valid"}, 32'(out_valid0), 32'd1);
      chk({vecs[v].name, "_m0"}, out_shares0, vecs[v].exp0);
      chk({vecs[v].name, "_m1"}, out_shares1, vecs[v].exp1);
      chk({vecs[v].name, "_m1_xor"},
          32'(out_shares1[7:0] ^ out_shares1[15:8] ^ out_shares1[23:16] ^ out_shares1[31:24]),
          32'(vecs[v].din[7:0] ^ vecs[v].din[15:8] ^ vecs[v].din[23:16] ^ vecs[v].din[31:24]));
    end
    chk("cnt_after_table", 32'(xfer_cnt0), 32'd7);

    // Data waits for randomness; randomness is consumed exactly once.
    @(negedge clk);
    pulses = 0;
    in_shares = 32'hA5A5_5A5A; rnd = '0; in_valid = 1'b1; rnd_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("wait_in_ready", 32'(in_ready0), 32'd1);
      if (rnd_ready0) pulses++;
      @(negedge clk);
    end
    chk("wait_no_fire_cnt", 32'(xfer_cnt0), 32'd7);
    rnd_valid = 1'b1;
    #1 if (rnd_ready0) pulses++;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 if (rnd_ready0) pulses++;
      @(negedge clk);
    end
    chk("wait_rnd_pulses", 32'(pulses), 32'd1);
    chk("wait_cnt", 32'(xfer_cnt0), 32'd8);
    rnd_valid = 1'b0;

    // Stream of 8 with output stalled on cycles 3..6.
    sent = 0; rcv = 0; saw_full = 1'b0; hold_vld = 1'b0; hold_val = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 8);
      rnd_valid = 1'b1;
      rnd       = '0;
      in_shares = item(sent);
      #1;
      if (hold_vld) begin
        chk("stall_hold_valid", 32'(out_valid0), 32'd1);
        chk("stall_hold_data", out_shares0, hold_val);
      end
      if (in_valid && !in_ready0) saw_full = 1'b1;
      f = in_valid & in_ready0;
      o = out_valid0 & out_ready;
      if (o) begin
        chk("stream_data", out_shares0, item(rcv));
        rcv++;
      end
      hold_vld = out_valid0 & !out_ready;
      hold_val = out_shares0;
      if (f) sent++;
    end
    in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b1;
    chk("stream_rcv_count", 32'(rcv), 32'd8);
    chk("stream_saw_full", 32'(saw_full), 32'd1);
    chk("stream_cnt", 32'(xfer_cnt0), 32'd16);

    // Flush with both stages occupied.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; rnd_valid = 1'b1; in_shares = 32'h1111_1111;
    @(negedge clk);
    in_shares = 32'h2222_2222;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("flush_pre_valid", 32'(out_valid0), 32'd1);
    cnt_b = xfer_cnt0;
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready0), 32'd0);
    chk("flush_rnd_ready", 32'(rnd_ready0), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_out_valid", 32'(out_valid0), 32'd0);
    chk("flush_cnt", 32'(xfer_cnt0), 32'(cnt_b));

    // Reset mid-stream, then drive the counter through its wrap.
    @(negedge clk);
    in_valid = 1'b1; rnd_valid = 1'b1; in_shares = 32'h3C3C_3C3C;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(out_valid0), 32'd0);
    chk("rst_mid_shares", out_shares0, 32'd0);
    chk("rst_mid_cnt", 32'(xfer_cnt0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (65535) @(negedge clk);
    in_valid = 1'b0;
    #1 chk("cnt_ffff", 32'(xfer_cnt0), 32'h0000_FFFF);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("cnt_wrap", 32'(xfer_cnt0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
